// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and helpers for the round-robin mux
package rr_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    localparam int SW  = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx,
    output logic          any_grant
);

    int start;
    int idx;

    // Scan from the start point upward with wrap; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        start     = (MODE == MODE_FIXED) ? 0 : int'(ptr);
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// rtl/rr_mux.sv - N-to-1 registered mux with valid/ready and built-in arbiter
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = MODE_RR,
    localparam int SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]  out_sel
);

    logic [SW-1:0] ptr;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          any_grant;
    logic          load_en;
    logic          take;

    rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign load_en  = !out_valid || out_ready;
    assign take     = load_en && any_grant;
    // Gated by rst_n so producers never see ready while the block is held in reset.
    assign in_ready = (rst_n && load_en) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
            out_sel   <= grant_idx;
            if (MODE == MODE_RR)
                ptr <= SW'(rr_next(int'(grant_idx), N));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// tb/tb_rr_mux.sv - self-checking bench for rr_mux in round-robin and fixed modes
module tb_rr_mux;

    localparam int N = 4;
    localparam int W = 8;
    localparam int SW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic [N-1:0]   in_ready_rr, in_ready_fx;
    logic           out_valid_rr, out_valid_fx;
    logic [W-1:0]   out_data_rr, out_data_fx;
    logic [SW-1:0]  out_sel_rr, out_sel_fx;

    int compared = 0;
    int mismatched = 0;

    // Reference state per instance: 0 = round-robin DUT, 1 = fixed-priority DUT.
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_sel   [2];
    int           m_ptr   [2];

    always #5 clk = ~clk;

    rr_mux #(.WIDTH(W), .N(N), .MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_rr),
        .in_data(in_data), .out_valid(out_valid_rr), .out_ready(out_ready),
        .out_data(out_data_rr), .out_sel(out_sel_rr)
    );

    rr_mux #(.WIDTH(W), .N(N), .MODE(1)) dut_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_fx),
        .in_data(in_data), .out_valid(out_valid_fx), .out_ready(out_ready),
        .out_data(out_data_fx), .out_sel(out_sel_fx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input int inst);
        int start;
        start = (inst == 0) ? m_ptr[inst] : 0;
        for (int k = 0; k < N; k++)
            if (in_valid[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready(input int inst);
        int g;
        g = model_grant(inst);
        if (rst_n && g >= 0 && (!m_valid[inst] || out_ready))
            return N'(1) << g;
        return '0;
    endfunction

    function automatic logic [N*W-1:0] a_pattern();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(8'hA0 + i);
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = '0; m_sel[i] = 0; m_ptr[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rr.in_ready"},  32'(in_ready_rr),  32'(model_ready(0)));
        chk({tag, ".rr.out_valid"}, 32'(out_valid_rr), 32'(m_valid[0]));
        chk({tag, ".rr.out_data"},  32'(out_data_rr),  32'(m_data[0]));
        chk({tag, ".rr.out_sel"},   32'(out_sel_rr),   32'(m_sel[0]));
        chk({tag, ".fx.in_ready"},  32'(in_ready_fx),  32'(model_ready(1)));
        chk({tag, ".fx.out_valid"}, 32'(out_valid_fx), 32'(m_valid[1]));
        chk({tag, ".fx.out_data"},  32'(out_data_fx),  32'(m_data[1]));
        chk({tag, ".fx.out_sel"},   32'(out_sel_fx),   32'(m_sel[1]));
    endtask

    // Drive inputs at the falling edge, check just after, then advance one cycle.
    task automatic step(input string tag, input logic [N-1:0] v, input logic r,
                        input logic [N*W-1:0] d);
        int g [2];
        logic ld [2];
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        #1;
        check_all(tag);
        for (int i = 0; i < 2; i++) begin
            g[i]  = model_grant(i);
            ld[i] = !m_valid[i] || r;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (g[i] >= 0 && ld[i]) begin
                m_valid[i] = 1'b1;
                m_data[i]  = d[g[i]*W +: W];
                m_sel[i]   = g[i];
                if (i == 0) m_ptr[i] = (g[i] + 1) % N;
            end else if (r) begin
                m_valid[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round-robin sweep at full throughput
        for (int i = 0; i < 2 * N; i++) step("rr_sweep", '1, 1'b1, a_pattern());
        chk("rr_sweep_sel_after_wrap", 32'(out_sel_rr), 32'(N - 1));

        // Backpressure with all channels requesting
        for (int i = 0; i < 3; i++) step("backpressure", '1, 1'b0, a_pattern());
        step("bp_release", '1, 1'b1, a_pattern());

        // Sparse requests on channels 1 and 3
        for (int i = 0; i < 5; i++) step("sparse", 4'b1010, 1'b1, a_pattern());

        // Fixed priority: 0 and 2 valid, then drop 0
        for (int i = 0; i < 3; i++) step("fixed_02", 4'b0101, 1'b1, a_pattern());
        chk("fixed_02_sel", 32'(out_sel_fx), 32'd0);
        for (int i = 0; i < 2; i++) step("fixed_2", 4'b0100, 1'b1, a_pattern());
        chk("fixed_2_sel", 32'(out_sel_fx), 32'd2);

        // Single word then idle drain
        step("idle_load", 4'b0010, 1'b1, a_pattern());
        for (int i = 0; i < 3; i++) step("idle_drain", '0, 1'b1, a_pattern());
        chk("idle_drain_valid", 32'(out_valid_rr), 32'd0);
        chk("idle_drain_data", 32'(out_data_rr), 32'hA1);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            step("random", N'($urandom), 1'($urandom_range(0, 3) != 0),
                 {$urandom, $urandom} & {(N*W){1'b1}});

        // Mid-stream reset with a word held under backpressure
        step("pre_reset", '1, 1'b0, a_pattern());
        step("pre_reset_hold", '1, 1'b0, a_pattern());
        chk("pre_reset_valid", 32'(out_valid_rr), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", '1, 1'b1, a_pattern());
        chk("post_reset_first_sel", 32'(out_sel_rr), 32'd0);
        chk("post_reset_first_data", 32'(out_data_rr), 32'hA0);
        step("post_reset_next", '1, 1'b1, a_pattern());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
